// File: rtl/strobe_counter_modal.sv
// Modal strobe counter: periodic/one-shot divider with load handshake and pipelined increment.
// Define COUNTER_MISS_COUNT_EN to build the saturating dropped-tick counter on missed.
module strobe_counter_modal #(
    parameter int WIDTH      = 16,
    parameter int LATENCY    = 1,
    parameter int RST_PERIOD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    input  logic             one_shot,
    output logic [WIDTH-1:0] count,
    output logic             strobe,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] missed
);

    localparam logic [WIDTH-1:0] RST_P = WIDTH'(RST_PERIOD);

    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] land_val;
    logic             mode_q;
    logic             done_q;
    logic             strobe_q;
    logic             busy;
    logic             land;
    logic             accept;
    logic             terminal;

    assign ready      = !busy && !done_q;
    assign accept     = enable && ready && !load;
    // period_q == 0 wraps to all-ones, giving the full 2^WIDTH range
    assign terminal   = count_q == period_q - WIDTH'(1);
    assign next_count = terminal ? '0 : count_q + WIDTH'(1);

    generate
        if (LATENCY == 1) begin : g_direct
            assign busy     = 1'b0;
            assign land     = accept;
            assign land_val = next_count;
        end else begin : g_pipe
            localparam int D = LATENCY - 1;
            logic [D-1:0]     vld;
            logic [WIDTH-1:0] val [D];

            always_ff @(posedge clk) begin
                if (rst || load) begin
                    vld <= '0;
                end else begin
                    vld <= D'({vld, accept});
                end
                val[0] <= next_count;
                for (int i = 1; i < D; i++) begin
                    val[i] <= val[i-1];
                end
            end

            // no new tick is accepted until the previous one has landed
            assign busy     = |vld;
            assign land     = vld[D-1];
            assign land_val = val[D-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= RST_P;
            mode_q   <= 1'b0;
            count_q  <= '0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= accept && terminal;
            if (load) begin
                period_q <= period;
                mode_q   <= one_shot;
                count_q  <= '0;
                done_q   <= 1'b0;
            end else begin
                if (land) begin
                    count_q <= land_val;
                end
                if (accept && terminal && mode_q) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

`ifdef COUNTER_MISS_COUNT_EN
    logic [WIDTH-1:0] missed_q;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            missed_q <= '0;
        end else if (enable && !accept && !(&missed_q)) begin
            missed_q <= missed_q + WIDTH'(1);
        end
    end

    assign missed = missed_q;
`else
    assign missed = '0;
`endif

    assign count  = count_q;
    assign strobe = strobe_q;
    assign done   = done_q;

endmodule

// File: tb/tb_strobe_counter_modal.sv
// Bench for strobe_counter_modal: two instances (LATENCY 1 and 3) against a timestamp model.
// Honours COUNTER_MISS_COUNT_EN when modelling the missed output.
module tb_strobe_counter_modal;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       load;
    logic [3:0] period;
    logic       one_shot;
    logic [3:0] count_o  [2];
    logic       strobe_o [2];
    logic       ready_o  [2];
    logic       done_o   [2];
    logic [3:0] missed_o [2];

    int n_cmp = 0;
    int n_bad = 0;

    strobe_counter_modal #(.WIDTH(4), .LATENCY(1), .RST_PERIOD(0)) u_l1 (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .period(period), .one_shot(one_shot),
        .count(count_o[0]), .strobe(strobe_o[0]), .ready(ready_o[0]),
        .done(done_o[0]), .missed(missed_o[0])
    );

    strobe_counter_modal #(.WIDTH(4), .LATENCY(3), .RST_PERIOD(6)) u_l3 (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .period(period), .one_shot(one_shot),
        .count(count_o[1]), .strobe(strobe_o[1]), .ready(ready_o[1]),
        .done(done_o[1]), .missed(missed_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: period as 1..16, settled count, one pending landing with timestamp
    int per_q  [2];
    bit os_q   [2];
    int cnt    [2];
    bit dn     [2];
    bit stb    [2];
    int mis    [2];
    int rdy_at [2];
    bit pend   [2];
    int pend_t [2];
    int pend_v [2];
    int cyc = 0;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int rstp(input int k);
        return (k == 0) ? 16 : 6;
    endfunction

    task automatic model_step();
        bit rdy;
        bit acc;
        bit term;
        int nv;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                per_q[k] = rstp(k); os_q[k] = 0; cnt[k] = 0; dn[k] = 0;
                stb[k] = 0; mis[k] = 0; rdy_at[k] = 0; pend[k] = 0;
            end else begin
                rdy  = (cyc >= rdy_at[k]) && !dn[k];
                acc  = enable && rdy && !load;
                term = acc && (cnt[k] == per_q[k] - 1);
                stb[k] = term;
                if (load) begin
                    per_q[k] = (period == 0) ? 16 : int'(period);
                    os_q[k] = one_shot; cnt[k] = 0; dn[k] = 0;
                    pend[k] = 0; rdy_at[k] = 0; mis[k] = 0;
                end else begin
                    if (pend[k] && pend_t[k] == cyc) begin
                        cnt[k] = pend_v[k];
                        pend[k] = 0;
                    end
                    if (acc) begin
                        nv = term ? 0 : cnt[k] + 1;
                        if (lat(k) == 1) cnt[k] = nv;
                        else begin
                            pend[k] = 1;
                            pend_t[k] = cyc + lat(k) - 1;
                            pend_v[k] = nv;
                        end
                        rdy_at[k] = cyc + lat(k);
                        if (term && os_q[k]) dn[k] = 1;
                    end else if (enable) begin
`ifdef COUNTER_MISS_COUNT_EN
                        if (mis[k] < 15) mis[k] = mis[k] + 1;
`endif
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic chk(input string nm, input int k,
                       input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got %0d expected %0d at %0t",
                     nm, k, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit l,
                        input logic [3:0] p, input bit o);
        rst = r; enable = e; load = l; period = p; one_shot = o;
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("count", k, 64'(count_o[k]), 64'(cnt[k]));
            chk("strobe", k, 64'(strobe_o[k]), 64'(stb[k]));
            chk("done", k, 64'(done_o[k]), 64'(dn[k]));
            chk("ready", k, 64'(ready_o[k]),
                64'((cyc >= rdy_at[k]) && !dn[k]));
            chk("missed", k, 64'(missed_o[k]), 64'(mis[k]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 4'd0, 0);
    endtask

    initial begin
        logic [3:0] p;
        bit r, l, e, o;
        int sel;

        step(1, 0, 0, 4'd0, 0);
        step(1, 1, 1, 4'd3, 1);
        chk("lit_rst_count", 0, 64'(count_o[0]), 64'd0);
        chk("lit_rst_ready", 0, 64'(ready_o[0]), 64'd1);
        chk("lit_rst_ready", 1, 64'(ready_o[1]), 64'd1);
        chk("lit_rst_done", 1, 64'(done_o[1]), 64'd0);

        // periodic, period 5
        step(0, 0, 1, 4'd5, 0);
        ticks(4);
        chk("lit_p5_count4", 0, 64'(count_o[0]), 64'd4);
        chk("lit_p5_nostb", 0, 64'(strobe_o[0]), 64'd0);
        ticks(1);
        chk("lit_p5_wrap", 0, 64'(count_o[0]), 64'd0);
        chk("lit_p5_strobe", 0, 64'(strobe_o[0]), 64'd1);
        chk("lit_l3_count", 1, 64'(count_o[1]), 64'd1);
        chk("lit_l3_busy", 1, 64'(ready_o[1]), 64'd0);
        ticks(10);

        // one-shot, period 2
        step(0, 1, 1, 4'd2, 1);
        ticks(10);
        chk("lit_os_done", 0, 64'(done_o[0]), 64'd1);
        chk("lit_os_ready", 0, 64'(ready_o[0]), 64'd0);
        chk("lit_os_done", 1, 64'(done_o[1]), 64'd1);
        chk("lit_os_count", 1, 64'(count_o[1]), 64'd0);
        step(0, 0, 1, 4'd4, 0);
        ticks(12);

        // full-range period then period 1
        step(0, 0, 1, 4'd0, 0);
        ticks(15);
        chk("lit_p16_count15", 0, 64'(count_o[0]), 64'd15);
        ticks(1);
        chk("lit_p16_strobe", 0, 64'(strobe_o[0]), 64'd1);
        step(0, 0, 1, 4'd1, 0);
        ticks(6);
        chk("lit_p1_strobe", 0, 64'(strobe_o[0]), 64'd1);
        chk("lit_p1_count", 0, 64'(count_o[0]), 64'd0);

        // load colliding with enable at count 2
        step(0, 0, 1, 4'd5, 0);
        ticks(2);
        step(0, 1, 1, 4'd5, 0);
        chk("lit_ldcol_count", 0, 64'(count_o[0]), 64'd0);
        chk("lit_ldcol_strobe", 0, 64'(strobe_o[0]), 64'd0);

        // reset with an increment in flight
        idle(3);
        ticks(1);
        step(1, 1, 0, 4'd0, 0);
        chk("lit_midrst_count", 1, 64'(count_o[1]), 64'd0);
        chk("lit_midrst_ready", 1, 64'(ready_o[1]), 64'd1);
        ticks(20);

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            l = ($urandom_range(0, 24) == 0);
            e = ($urandom_range(0, 9) < 7);
            o = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            if (sel == 0) p = 4'd0;
            else if (sel == 1) p = 4'd1;
            else p = 4'($urandom_range(0, 15));
            step(r, e, l, p, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/strobe_counter_modal.md
Name: strobe_counter_modal

Overview:
Parametrised successor to the team's strobe counter. It counts accepted ticks modulo a runtime-loadable period and emits a one-cycle strobe on each terminal tick. It adds periodic and one-shot modes, an explicit load handshake, a readable count, a full-range period encoding and defined drop behaviour for ticks offered while not ready. It sits between tick sources (baud/prescaler enables) and consumers needing divided strobes.

Parameters:
WIDTH, 16, bit width of count and period; 2..64.
LATENCY, 1, pipeline stages of the increment adder; 1..WIDTH; count update visible LATENCY cycles after an accepted tick.
RST_PERIOD, 16, period in force after reset; 0 means 2^WIDTH.

Ports:
clk  in  1  single clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
enable  in  1  tick request; accepted only when enable && ready && !load.
load  in  1  one-cycle pulse; latch period and mode, clear count.
period  in  WIDTH  terminal period sampled on load; 0 encodes 2^WIDTH.
one_shot  in  1  mode sampled on load: 0 periodic, 1 one-shot.
count  out  WIDTH  accepted ticks since last wrap/load, 0..period-1.
strobe  out  1  one-cycle pulse after each terminal tick.
ready  out  1  a tick may be accepted this cycle.
done  out  1  one-shot has fired and is halted.
missed  out  WIDTH  saturating dropped-tick count (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge): count=0, strobe=0, done=0, missed=0, ready=1 from the next cycle, period_q=RST_PERIOD, mode_q=periodic. Pipeline contents discarded. rst dominates load and enable.
- Accept: tick accepted at edge E when enable && ready && !load && !done.
- Terminal tick: accepted while count == period_q-1 (modulo 2^WIDTH, so period_q=0 terminates at all-ones). Count becomes 0, visible after LATENCY cycles. strobe=1 in the cycle after E, for exactly one cycle.
- Non-terminal tick: count becomes count+1, visible LATENCY cycles after E.
- Terminal decision uses the settled count. Never compare a partially propagated pipeline value.
- ready:
  - LATENCY=1: ready stays 1 (except when done=1); back-to-back ticks are legal.
  - LATENCY>1: ready=0 for the LATENCY-1 cycles after an accepted tick, then returns to 1.
  - ready=0 whenever done=1.
- Dropped tick: enable=1 with ready=0, done=1 or load=1. It has no effect on count or strobe, only on missed.
- period=1 (period_q=1): every accepted tick is terminal; count stays 0.
- One-shot mode: after the terminal tick, done=1 from the strobe cycle onward. Count holds 0 and further ticks are dropped until load or rst.
- Periodic mode: count wraps to 0 and counting continues; done stays 0.
- Load at edge L:
  - period_q and mode_q latched; count=0 visible the next cycle; done=0.
  - Any in-flight increment is aborted and an in-flight strobe is not suppressed.
  - ready=1 the next cycle.
- Load and enable in the same cycle: load wins and the tick is dropped.
- Changing period or one_shot without load has no effect.
- count is stable whenever ready=1. While ready=0 it holds the previous value until the update lands.

Optional Feature:
COUNTER_MISS_COUNT_EN:
- Defined: missed increments by 1 on each dropped tick and saturates at all-ones. It is cleared by rst and by load.
- Undefined: missed is constant 0 and the counter logic is not synthesised. The port still exists.

Test Plan:
1. WIDTH=8, LATENCY=1, load period=5 periodic, enable held 1 for 12 cycles -> strobe in cycles 6 and 11 after first accept; count sequence 1,2,3,4,0,1...; ready always 1.
2. WIDTH=8, LATENCY=4, period=3, enable held 1 -> ticks accepted every 4th cycle; strobe one cycle after the 3rd and 6th accepts; missed=3 per accepted tick with COUNTER_MISS_COUNT_EN.
3. One-shot, period=2, enable held 1 -> single strobe after 2nd accept; done=1 and ready=0 thereafter; count holds 0; reload period=4 -> done=0 and counting resumes.
4. Load period=0, WIDTH=4, 16 accepted ticks -> one strobe on the 16th; period=1 -> strobe after every accept.
5. Load asserted together with enable while count=2 -> tick dropped, count=0 next cycle, no strobe; rst asserted mid-pipeline (LATENCY=3) -> count=0, strobe=0, period_q=RST_PERIOD, ready=1 the next cycle.
